// File: rtl/sensor_cond_gen.sv
// sensor_cond_gen: current/torque exponential filters, hysteretic low-battery flag and clamped current error
module sensor_cond_gen #(
    parameter bit           FAST_SIM       = 1'b1,
    parameter int           W              = 12,
    parameter int           CURR_SHIFT     = 2,
    parameter int           TORQ_SHIFT     = 5,
    parameter logic [W-1:0] LOW_BATT_THRES = 12'hA98,
    parameter logic [W-1:0] BATT_HYST      = 12'h020,
    parameter int           ERR_LIM        = (1 << W) - 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [W-1:0]        curr,
    input  logic [W-1:0]        torque,
    input  logic [W-1:0]        batt,
    input  logic [W-1:0]        target_curr,
    input  logic                cadence_rise,
    input  logic                not_pedaling,
    output logic [W-1:0]        avg_curr,
    output logic [W-1:0]        avg_torque,
    output logic                curr_valid,
    output logic                low_batt,
    output logic signed [W:0]   error
);
    localparam int S = FAST_SIM ? 16 : 22;
    localparam int N = CURR_SHIFT;
    localparam int M = TORQ_SHIFT;
    localparam logic signed [W:0] LIM = (W+1)'(ERR_LIM);
    localparam logic [W:0] REL = {1'b0, LOW_BATT_THRES} + {1'b0, BATT_HYST};

    logic [S-1:0]      r_tmr;
    logic [W+N-1:0]    r_ca;
    logic [W+M-1:0]    r_ta;
    logic              r_np;
    logic              r_lb;
    logic              r_cv;
    logic signed [W:0] r_err;
    logic              w_smpl;
    logic              w_res;
    logic signed [W:0] w_diff;
    logic signed [W:0] w_err;

    assign w_smpl = &r_tmr;
    assign w_res  = r_np & ~not_pedaling;
    assign w_diff = $signed({1'b0, target_curr}) - $signed({1'b0, avg_curr});

    always_comb
        w_err = (not_pedaling | r_lb) ? '0 :
                (w_diff > LIM)        ? LIM :
                (w_diff < -LIM)       ? -LIM : w_diff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmr <= '0;
            r_ca  <= '0;
            r_ta  <= '0;
            r_np  <= 1'b0;
            r_lb  <= 1'b1;
            r_cv  <= 1'b0;
            r_err <= '0;
        end else begin
            r_tmr <= r_tmr + S'(1);
            r_cv  <= w_smpl;
            r_np  <= not_pedaling;
            r_err <= w_err;
            if (w_smpl) begin
                r_ca <= r_ca - (r_ca >> N) + {{N{1'b0}}, curr};
                r_lb <= (batt < LOW_BATT_THRES) ? 1'b1 : ({1'b0, batt} >= REL) ? 1'b0 : r_lb;
            end
            // a resume seeds the torque filter at half the current torque, overriding any cadence update
            if (w_res)
                r_ta <= {{M{1'b0}}, torque} << (M - 1);
            else if (cadence_rise)
                r_ta <= r_ta - (r_ta >> M) + {{M{1'b0}}, torque};
        end
    end

    assign avg_curr   = r_ca[W+N-1:N];
    assign avg_torque = r_ta[W+M-1:M];
    assign curr_valid = r_cv;
    assign low_batt   = r_lb;
    assign error      = r_err;
endmodule

// File: tb/tb_sensor_cond_gen.sv
// tb_sensor_cond_gen: randomized and directed checks of sensor_cond_gen against an arithmetic reference model
module tb_sensor_cond_gen;
    localparam int N   = 2;
    localparam int M   = 5;
    localparam int LIM = 'h200;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [11:0] curr = '0, torque = '0, batt = '0, target_curr = '0;
    logic cadence_rise = 1'b0, not_pedaling = 1'b0;
    logic [11:0] avg_curr, avg_torque;
    logic curr_valid, low_batt;
    logic signed [12:0] error;

    int errors = 0;
    int checks = 0;

    int m_tmr = 0, m_ca = 0, m_ta = 0, m_err = 0;
    bit m_np = 1'b0, m_lb = 1'b1, m_cv = 1'b0;
    bit ffwd = 1'b0;
    logic m_smp;

    sensor_cond_gen #(.FAST_SIM(1'b1), .W(12), .CURR_SHIFT(N), .TORQ_SHIFT(M),
                      .LOW_BATT_THRES(12'hA98), .BATT_HYST(12'h020), .ERR_LIM(LIM)) dut (
        .clk(clk), .rst_n(rst_n), .curr(curr), .torque(torque), .batt(batt),
        .target_curr(target_curr), .cadence_rise(cadence_rise), .not_pedaling(not_pedaling),
        .avg_curr(avg_curr), .avg_torque(avg_torque), .curr_valid(curr_valid),
        .low_batt(low_batt), .error(error)
    );

    always #5 clk = ~clk;

    function automatic int clamp_err(int target, int avg, bit gate);
        int d;
        d = target - avg;
        if (gate) return 0;
        if (d > LIM) return LIM;
        if (d < -LIM) return -LIM;
        return d;
    endfunction

    assign m_smp = (m_tmr == 65535) || ffwd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tmr <= 0; m_ca <= 0; m_ta <= 0; m_np <= 1'b0; m_lb <= 1'b1; m_cv <= 1'b0; m_err <= 0;
        end else begin
            m_err <= clamp_err(int'(target_curr), m_ca / (1 << N), not_pedaling || m_lb);
            m_cv  <= m_smp;
            m_np  <= not_pedaling;
            m_tmr <= m_smp ? 0 : m_tmr + 1;
            if (m_smp) begin
                m_ca <= m_ca - m_ca / (1 << N) + int'(curr);
                m_lb <= (batt < 12'hA98) ? 1'b1 : (int'(batt) >= 'hA98 + 'h20) ? 1'b0 : m_lb;
            end
            if (m_np && !not_pedaling)
                m_ta <= int'(torque) * (1 << (M - 1));
            else if (cadence_rise)
                m_ta <= m_ta - m_ta / (1 << M) + int'(torque);
        end
    end

    // jump the sample timer to all-ones so the next edge is a sample edge
    task automatic do_sample();
        @(negedge clk);
        force dut.r_tmr = '1;
        ffwd = 1'b1;
        #1 release dut.r_tmr;
        @(negedge clk);
        ffwd = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        checks++; if (avg_curr !== 12'h000) begin errors++; $display("FAIL reset avg_curr: got %h want 000", avg_curr); end
        checks++; if (avg_torque !== 12'h000) begin errors++; $display("FAIL reset avg_torque: got %h want 000", avg_torque); end
        checks++; if (curr_valid !== 1'b0) begin errors++; $display("FAIL reset curr_valid: got %b want 0", curr_valid); end
        checks++; if (low_batt !== 1'b1) begin errors++; $display("FAIL reset low_batt: got %b want 1", low_batt); end
        checks++; if (error !== 13'h0) begin errors++; $display("FAIL reset error: got %h want 0", error); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_torque();
        @(negedge clk);
        not_pedaling = 1'b1; torque = 12'h800;
        @(negedge clk);
        not_pedaling = 1'b0;
        @(negedge clk);
        checks++; if (avg_torque !== 12'h400) begin errors++; $display("FAIL torque seed: got %h want 400", avg_torque); end
        cadence_rise = 1'b1;
        @(negedge clk);
        cadence_rise = 1'b0;
        checks++; if (avg_torque !== 12'h420) begin errors++; $display("FAIL torque accum: got %h want 420", avg_torque); end
        not_pedaling = 1'b1;
        @(negedge clk);
        not_pedaling = 1'b0; cadence_rise = 1'b1; torque = 12'h600;
        @(negedge clk);
        cadence_rise = 1'b0;
        checks++; if (avg_torque !== 12'h300) begin errors++; $display("FAIL torque seed priority: got %h want 300", avg_torque); end
        for (int i = 0; i < 40; i++) begin
            torque = 12'($urandom);
            cadence_rise = 1'($urandom_range(0, 1));
            not_pedaling = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            checks++;
            if (avg_torque !== 12'(m_ta / (1 << M))) begin
                errors++; $display("FAIL torque random %0d: got %h want %h", i, avg_torque, 12'(m_ta / (1 << M)));
            end
        end
        cadence_rise = 1'b0; not_pedaling = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        curr = 12'h400; batt = 12'hC00; target_curr = 12'h300;
        do_sample();
        checks++; if (avg_curr !== 12'h100) begin errors++; $display("FAIL first sample avg_curr: got %h want 100", avg_curr); end
        checks++; if (curr_valid !== 1'b1) begin errors++; $display("FAIL first sample curr_valid: got %b want 1", curr_valid); end
        @(negedge clk);
        checks++; if (error !== 13'h200) begin errors++; $display("FAIL pre-reset error: got %h want 200", error); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (avg_curr !== 12'h000) begin errors++; $display("FAIL midreset avg_curr: got %h want 000", avg_curr); end
        checks++; if (avg_torque !== 12'h000) begin errors++; $display("FAIL midreset avg_torque: got %h want 000", avg_torque); end
        checks++; if (error !== 13'h0) begin errors++; $display("FAIL midreset error: got %h want 0", error); end
        checks++; if (low_batt !== 1'b1) begin errors++; $display("FAIL midreset low_batt: got %b want 1", low_batt); end
    endtask

    task automatic test_interval();
        int n;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (curr_valid !== 1'b1 && n < 70000) begin
            @(negedge clk);
            n++;
            if (curr_valid !== 1'b1 && error !== 13'h0) begin
                errors++; checks++; $display("FAIL error before first sample: got %h want 0", error);
            end
        end
        checks++; if (n != 65536) begin errors++; $display("FAIL sample interval: got %0d want 65536", n); end
        checks++; if (avg_curr !== 12'h100) begin errors++; $display("FAIL interval avg_curr: got %h want 100", avg_curr); end
        checks++; if (low_batt !== 1'b0) begin errors++; $display("FAIL interval low_batt: got %b want 0", low_batt); end
        checks++; if (error !== 13'h0) begin errors++; $display("FAIL interval error: got %h want 0", error); end
        @(negedge clk);
        checks++; if (curr_valid !== 1'b0) begin errors++; $display("FAIL curr_valid width: got %b want 0", curr_valid); end
        checks++; if (error !== 13'h200) begin errors++; $display("FAIL interval error after clear: got %h want 200", error); end
    endtask

    task automatic test_error_clamp();
        logic [11:0] tg [5];
        logic [12:0] ex [5];
        tg = '{12'h800, 12'h180, 12'h000, 12'h2FF, 12'h301};
        ex = '{13'h0200, 13'h0080, 13'h1F00, 13'h01FF, 13'h0200};
        for (int i = 0; i < 5; i++) begin
            target_curr = tg[i];
            @(negedge clk);
            checks++;
            if (error !== ex[i] || error !== 13'(m_err)) begin
                errors++; $display("FAIL clamp %0d: got %0d want %0d", i, error, $signed(ex[i]));
            end
        end
    endtask

    task automatic test_gating();
        target_curr = 12'h180;
        not_pedaling = 1'b1;
        @(negedge clk);
        checks++; if (error !== 13'h0) begin errors++; $display("FAIL gate on: got %h want 0", error); end
        @(negedge clk);
        not_pedaling = 1'b0;
        @(negedge clk);
        checks++; if (error !== 13'h080) begin errors++; $display("FAIL gate release: got %h want 080", error); end
    endtask

    task automatic test_curr_filter();
        curr = 12'h400;
        do_sample();
        checks++; if (avg_curr !== 12'h1C0) begin errors++; $display("FAIL conv 2nd: got %h want 1C0", avg_curr); end
        do_sample();
        checks++; if (avg_curr !== 12'h250) begin errors++; $display("FAIL conv 3rd: got %h want 250", avg_curr); end
        for (int i = 0; i < 40; i++) do_sample();
        checks++; if (avg_curr !== 12'h400) begin errors++; $display("FAIL conv final: got %h want 400", avg_curr); end
        target_curr = 12'h000;
        @(negedge clk);
        checks++; if (error !== 13'h1E00) begin errors++; $display("FAIL clamp negative: got %0d want -512", error); end
    endtask

    task automatic test_batt();
        logic [11:0] bv [7];
        bit          lb [7];
        bv = '{12'hB00, 12'hA97, 12'hAA0, 12'hAB7, 12'hAB8, 12'hA98, 12'hA97};
        lb = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            batt = bv[i];
            do_sample();
            checks++;
            if (low_batt !== lb[i]) begin errors++; $display("FAIL batt %h: got %b want %b", bv[i], low_batt, lb[i]); end
            @(negedge clk);
            checks++;
            if (error !== (lb[i] ? 13'h0 : 13'h1E00)) begin
                errors++; $display("FAIL batt gate %h: got %h want %h", bv[i], error, lb[i] ? 13'h0 : 13'h1E00);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            curr = 12'($urandom);
            torque = 12'($urandom);
            batt = 12'($urandom_range('hA80, 'hAC0));
            target_curr = 12'($urandom);
            cadence_rise = 1'($urandom_range(0, 1));
            not_pedaling = ($urandom_range(0, 7) == 0);
            if (i % 8 == 0) do_sample(); else @(negedge clk);
            checks++;
            if (avg_curr !== 12'(m_ca / (1 << N)) || avg_torque !== 12'(m_ta / (1 << M)) ||
                curr_valid !== m_cv || low_batt !== m_lb || error !== 13'(m_err)) begin
                errors++;
                $display("FAIL random %0d: got c=%h t=%h v=%b l=%b e=%0d want c=%h t=%h v=%b l=%b e=%0d", i,
                         avg_curr, avg_torque, curr_valid, low_batt, error,
                         12'(m_ca / (1 << N)), 12'(m_ta / (1 << M)), m_cv, m_lb, m_err);
            end
        end
        cadence_rise = 1'b0; not_pedaling = 1'b0;
    endtask

    initial begin
        test_reset();
        test_torque();
        test_mid_reset();
        test_interval();
        test_error_clamp();
        test_gating();
        test_curr_filter();
        test_batt();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
